pll_lock_detect: RTL and testbench

Lock detector placed directly downstream of the TDC in the jitter-attenuator loop, in parallel with the digital loop filter on the reference clock. It qualifies each signed phase-error sample against a programmable window and runs a hysteretic state machine. The machine declares lock after a run of consecutive in-window samples and loss of lock after a run of consecutive misses. Its outputs feed loop-status reporting and any bandwidth/gear-shift control that keys off lock.

---
 rtl/pll_lock_detect.sv | 152 +++++++++++++++
 tb/tb_pll_lock_detect.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_detect.sv
// Hysteretic PLL lock detector: qualifies TDC phase-error samples against a window.
// Optional sticky loss-of-lock flag enabled by defining PLL_LOCK_DET_STICKY_LOL_EN.
module pll_lock_detect #(
    parameter int ERR_WIDTH    = 7,
    parameter int LOCK_THRESH  = 4,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [ERR_WIDTH-1:0] phase_err,
    input  logic                        err_valid,
    input  logic                        lol_clr,
    output logic                        locked,
    output logic [1:0]                  lock_state,
    output logic                        in_window,
    output logic [CNT_WIDTH-1:0]        lock_cnt,
    output logic                        lol_sticky
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [ERR_WIDTH:0]   THRESH      = (ERR_WIDTH+1)'(LOCK_THRESH);
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                   win_reg, win_next;
    logic                   locked_reg;
    logic                   lol_event;
    logic [ERR_WIDTH:0]     err_ext;
    logic [ERR_WIDTH:0]     err_mag;
    logic                   hit;

    // One extra bit so the most-negative code maps to +2^(ERR_WIDTH-1) without wrapping.
    assign err_ext = {phase_err[ERR_WIDTH-1], phase_err};
    assign err_mag = err_ext[ERR_WIDTH] ? (~err_ext + 1'b1) : err_ext;
    assign hit     = (err_mag <= THRESH);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        win_next   = win_reg;
        lol_event  = 1'b0;
        if (err_valid) begin
            win_next = hit;
            case (state_reg)
                UNLOCKED: begin
                    if (hit) begin
                        if (LOCK_COUNT == 1) begin
                            state_next = LOCKED;
                            cnt_next   = '0;
                        end else begin
                            state_next = ACQUIRE;
                            cnt_next   = CNT_ONE;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                ACQUIRE: begin
                    if (!hit) begin
                        state_next = UNLOCKED;
                        cnt_next   = '0;
                    end else if (cnt_reg == LOCK_LAST) begin
                        state_next = LOCKED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        if (UNLOCK_COUNT == 1) begin
                            state_next = UNLOCKED;
                            cnt_next   = '0;
                            lol_event  = 1'b1;
                        end else begin
                            state_next = HOLD;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (hit) begin
                        state_next = LOCKED;
                        cnt_next   = '0;
                    end else if (cnt_reg == UNLOCK_LAST) begin
                        state_next = UNLOCKED;
                        cnt_next   = '0;
                        lol_event  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = UNLOCKED;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= UNLOCKED;
            cnt_reg    <= '0;
            win_reg    <= 1'b0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            win_reg    <= win_next;
            locked_reg <= (state_next == LOCKED) || (state_next == HOLD);
        end
    end

    assign locked     = locked_reg;
    assign lock_state = state_reg;
    assign in_window  = win_reg;
    assign lock_cnt   = cnt_reg;

`ifdef PLL_LOCK_DET_STICKY_LOL_EN
    logic lol_reg;

    // A coincident event beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lol_reg <= 1'b0;
        end else if (lol_event) begin
            lol_reg <= 1'b1;
        end else if (lol_clr) begin
            lol_reg <= 1'b0;
        end
    end

    assign lol_sticky = lol_reg;
`else
    logic unused_lol;
    assign unused_lol = lol_clr ^ lol_event;
    assign lol_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
// Scoreboard bench for pll_lock_detect: a run-length reference model pushes expected
// output vectors per sample; each scenario task pops and compares them.
module tb_pll_lock_detect;

    localparam int EW = 7;
    localparam int CW = 8;
    localparam int LOCK_N = 64;
    localparam int UNLOCK_N = 4;
    localparam int THR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [EW-1:0] phase_err = '0;
    logic          err_valid = 1'b0;
    logic          lol_clr = 1'b0;
    logic          locked;
    logic [1:0]    lock_state;
    logic          in_window;
    logic [CW-1:0] lock_cnt;
    logic          lol_sticky;

    int n_cmp = 0;
    int n_err = 0;

    // Packed output vector: {locked, lock_state, in_window, lock_cnt, lol_sticky}
    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];
    logic [12:0] exp_v, obs_v;

    // Reference model: track run lengths instead of an explicit state code.
    bit m_lock;
    int hit_run, miss_run;
    bit m_win, m_sticky;

    pll_lock_detect #(
        .ERR_WIDTH(EW), .LOCK_THRESH(THR), .LOCK_COUNT(LOCK_N),
        .UNLOCK_COUNT(UNLOCK_N), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .phase_err(phase_err), .err_valid(err_valid),
        .lol_clr(lol_clr), .locked(locked), .lock_state(lock_state),
        .in_window(in_window), .lock_cnt(lock_cnt), .lol_sticky(lol_sticky)
    );

    always #5 clk = ~clk;

    task automatic reset_model();
        m_lock = 0; hit_run = 0; miss_run = 0; m_win = 0; m_sticky = 0;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic step(input bit v, input int e, input bit clr);
        int mag;
        bit hit, ev;
        logic [1:0] st;
        logic [CW-1:0] cnt;
        ev = 0;
        err_valid = v; phase_err = e[EW-1:0]; lol_clr = clr;
        if (v) begin
            mag = (e < 0) ? -e : e;
            hit = (mag <= THR);
            m_win = hit;
            if (!m_lock) begin
                if (hit) begin
                    hit_run++;
                    if (hit_run == LOCK_N) begin m_lock = 1; hit_run = 0; miss_run = 0; end
                end else hit_run = 0;
            end else begin
                if (hit) miss_run = 0;
                else begin
                    miss_run++;
                    if (miss_run == UNLOCK_N) begin m_lock = 0; miss_run = 0; hit_run = 0; ev = 1; end
                end
            end
        end
`ifdef PLL_LOCK_DET_STICKY_LOL_EN
        if (ev) m_sticky = 1;
        else if (clr) m_sticky = 0;
`endif
        st  = m_lock ? ((miss_run > 0) ? 2'd3 : 2'd2) : ((hit_run > 0) ? 2'd1 : 2'd0);
        cnt = m_lock ? CW'(miss_run) : CW'(hit_run);
        exp_q.push_back({m_lock, st, m_win, cnt, m_sticky});
        @(posedge clk); #1;
        obs_q.push_back({locked, lock_state, in_window, lock_cnt, lol_sticky});
        err_valid = 0; lol_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({locked, lock_state, in_window, lock_cnt, lol_sticky} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 0000 (locked,state,win,cnt,lol)",
                     {locked, lock_state, in_window, lock_cnt, lol_sticky});
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_acquire();
        for (int i = 0; i < LOCK_N; i++) step(1, 3, 0);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); obs_v = obs_q.pop_front(); n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL acquire: got %h expected %h", obs_v, exp_v);
            end
        end
        n_cmp++;
        if (locked !== 1'b1 || lock_state !== 2'd2) begin
            n_err++;
            $display("FAIL acquire_lock: got locked=%0b state=%0d expected locked=1 state=2", locked, lock_state);
        end
    endtask

    task automatic test_threshold();
        int pat[8] = '{4, 0, -4, 5, -5, -64, 3, -63};
        for (int i = 0; i < UNLOCK_N; i++) step(1, -64, 0);
        foreach (pat[i]) step(1, pat[i], 0);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); obs_v = obs_q.pop_front(); n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL threshold: got %h expected %h", obs_v, exp_v);
            end
        end
    endtask

    task automatic test_interrupted();
        for (int i = 0; i < 30; i++) step(1, $urandom_range(0, 8) - 4, 0);
        step(1, 5, 0);
        for (int i = 0; i < LOCK_N; i++) step(1, -2, 0);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); obs_v = obs_q.pop_front(); n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL interrupted: got %h expected %h", obs_v, exp_v);
            end
        end
    endtask

    task automatic test_grace();
        for (int i = 0; i < UNLOCK_N - 1; i++) step(1, -10, 0);
        step(1, 0, 0);
        step(1, 10, 0);
        step(1, 1, 0);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); obs_v = obs_q.pop_front(); n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL grace: got %h expected %h", obs_v, exp_v);
            end
        end
    endtask

    task automatic test_loss();
        for (int i = 0; i < UNLOCK_N; i++) step(1, -64, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < LOCK_N; i++) step(1, 1, 0);
        for (int i = 0; i < UNLOCK_N - 1; i++) step(1, 20, 0);
        step(1, 20, 1);
        step(1, 0, 0);
        step(0, 0, 1);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); obs_v = obs_q.pop_front(); n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL loss: got %h expected %h", obs_v, exp_v);
            end
        end
    endtask

    task automatic test_valid_gating();
        for (int i = 0; i < 20; i++) step(1, 4, 0);
        for (int i = 0; i < 100; i++) step(0, 60, 0);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); obs_v = obs_q.pop_front(); n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL valid_gating: got %h expected %h", obs_v, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < LOCK_N; i++) step(1, 0, 0);
        for (int i = 0; i < UNLOCK_N; i++) step(1, -64, 0);
        for (int i = 0; i < LOCK_N; i++) step(1, 0, 0);
        step(1, -30, 0);
        step(1, -30, 0);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); obs_v = obs_q.pop_front(); n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL async_pre: got %h expected %h", obs_v, exp_v);
            end
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({locked, lock_state, in_window, lock_cnt, lol_sticky} !== 13'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h expected 0000",
                     {locked, lock_state, in_window, lock_cnt, lol_sticky});
        end
        reset_model();
        @(negedge clk); rst = 0;
        step(1, 2, 0);
        exp_v = exp_q.pop_front(); obs_v = obs_q.pop_front(); n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL after_reset: got %h expected %h", obs_v, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_threshold();
        test_interrupted();
        test_grace();
        test_loss();
        test_valid_gating();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
